// File: rtl/mem_stage_hs.sv
// Load/store stage with a req/gnt + rvalid data-bus handshake and a timeout.
// Non-memory instructions and rejected (misaligned/illegal) accesses pass straight to writeback.
module mem_stage_hs #(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_vld,
  input  logic [2:0]        i_opsel,
  input  logic              i_dmem_ren,
  input  logic              i_dmem_wen,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  input  logic [31:0]       i_res,
  input  logic [4:0]        i_rd_waddr,
  input  logic              i_rd_wen,
  output logic              o_stall,
  output logic              o_req,
  input  logic              i_gnt,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [31:0]       o_bus_wdata,
  output logic [3:0]        o_bus_mask,
  output logic              o_bus_wen,
  input  logic              i_rvalid,
  input  logic [31:0]       i_rdata,
  output logic              o_vld,
  output logic [4:0]        o_rd_waddr,
  output logic              o_rd_wen,
  output logic [31:0]       o_wb_data,
  output logic              o_misalign,
  output logic              o_bus_err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        mask_q;
  logic [31:0]       wdata_q;
  logic [2:0]        opsel_q;
  logic [4:0]        rd_q;
  logic              rd_wen_q, is_ld_q, err_q, req_q;
  logic [31:0]       ldata_q;
  logic              vld_q, wb_wen_q, mis_q, berr_q;
  logic [4:0]        wb_rd_q;
  logic [31:0]       wb_data_q;

  logic        access, illegal, misal, mem_op, is_ld;
  logic [3:0]  mask_d;
  logic [31:0] bwdata_d, lane, ldata_d;

  always_comb begin
    access  = i_vld & (i_dmem_ren | i_dmem_wen);
    illegal = (i_opsel == 3'b011) | (i_opsel[2:1] == 2'b11);
    misal   = ((i_opsel[1:0] == 2'b01) & i_addr[0]) |
              ((i_opsel[1:0] == 2'b10) & (i_addr[1:0] != 2'b00));
    mem_op  = access & ~(illegal | misal);
    is_ld   = i_dmem_ren & ~i_dmem_wen;
    case (i_opsel[1:0])
      2'b00: begin
        mask_d   = 4'b0001 << i_addr[1:0];
        bwdata_d = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        mask_d   = i_addr[1] ? 4'b1100 : 4'b0011;
        bwdata_d = {2{i_wdata[15:0]}};
      end
      default: begin
        mask_d   = 4'b1111;
        bwdata_d = i_wdata;
      end
    endcase
    // Bring the addressed lane down to bit 0, then extend per opsel[2].
    lane = i_rdata >> {addr_q[1:0], 3'b000};
    case (opsel_q[1:0])
      2'b00:   ldata_d = {{24{lane[7] & ~opsel_q[2]}}, lane[7:0]};
      2'b01:   ldata_d = {{16{lane[15] & ~opsel_q[2]}}, lane[15:0]};
      default: ldata_d = lane;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      mask_q    <= '0;
      wdata_q   <= '0;
      opsel_q   <= '0;
      rd_q      <= '0;
      rd_wen_q  <= 1'b0;
      is_ld_q   <= 1'b0;
      err_q     <= 1'b0;
      req_q     <= 1'b0;
      ldata_q   <= '0;
      vld_q     <= 1'b0;
      wb_wen_q  <= 1'b0;
      mis_q     <= 1'b0;
      berr_q    <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      vld_q    <= 1'b0;
      wb_wen_q <= 1'b0;
      mis_q    <= 1'b0;
      berr_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_op) begin
            addr_q   <= i_addr;
            mask_q   <= mask_d;
            wdata_q  <= bwdata_d;
            opsel_q  <= i_opsel;
            rd_q     <= i_rd_waddr;
            rd_wen_q <= i_rd_wen;
            is_ld_q  <= is_ld;
            err_q    <= 1'b0;
            ldata_q  <= '0;
            cnt_q    <= '0;
            req_q    <= 1'b1;
            state_q  <= REQ;
          end else begin
            vld_q     <= i_vld;
            wb_rd_q   <= i_rd_waddr;
            wb_wen_q  <= i_rd_wen & i_vld & ~access;
            wb_data_q <= i_res;
            mis_q     <= access;
          end
        end
        REQ: begin
          if (i_gnt) begin
            req_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= is_ld_q ? WAIT : DONE;
          end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT: begin
          if (i_rvalid) begin
            ldata_q <= ldata_d;
            state_q <= DONE;
          end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          vld_q     <= 1'b1;
          wb_rd_q   <= rd_q;
          wb_wen_q  <= rd_wen_q & is_ld_q & ~err_q;
          wb_data_q <= (is_ld_q & ~err_q) ? ldata_q : 32'h0;
          berr_q    <= err_q;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Rejected accesses never stall: only a legal op waiting in IDLE does.
  assign o_stall     = (state_q == REQ) | (state_q == WAIT) | ((state_q == IDLE) & mem_op);
  assign o_req       = req_q;
  assign o_bus_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign o_bus_wdata = wdata_q;
  assign o_bus_mask  = mask_q;
  assign o_bus_wen   = ~is_ld_q;
  assign o_vld       = vld_q;
  assign o_rd_waddr  = wb_rd_q;
  assign o_rd_wen    = wb_wen_q;
  assign o_wb_data   = wb_data_q;
  assign o_misalign  = mis_q;
  assign o_bus_err   = berr_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Scoreboard bench for mem_stage_hs: expected writebacks are queued at issue and
// compared by a monitor whenever o_vld is seen.
module tb_mem_stage_hs;

  localparam int MAX_WAIT = 15;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_vld, i_dmem_ren, i_dmem_wen, i_rd_wen, i_gnt, i_rvalid;
  logic [2:0]  i_opsel;
  logic [31:0] i_addr, i_wdata, i_res, i_rdata;
  logic [4:0]  i_rd_waddr;
  logic        o_stall, o_req, o_bus_wen, o_vld, o_rd_wen, o_misalign, o_bus_err;
  logic [31:0] o_bus_addr, o_bus_wdata, o_wb_data;
  logic [3:0]  o_bus_mask;
  logic [4:0]  o_rd_waddr;

  typedef struct {
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] data;
    logic        mis;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_stage_hs #(.ADDR_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_vld(i_vld), .i_opsel(i_opsel),
    .i_dmem_ren(i_dmem_ren), .i_dmem_wen(i_dmem_wen), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_res(i_res), .i_rd_waddr(i_rd_waddr), .i_rd_wen(i_rd_wen),
    .o_stall(o_stall), .o_req(o_req), .i_gnt(i_gnt), .o_bus_addr(o_bus_addr),
    .o_bus_wdata(o_bus_wdata), .o_bus_mask(o_bus_mask), .o_bus_wen(o_bus_wen),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .o_vld(o_vld), .o_rd_waddr(o_rd_waddr),
    .o_rd_wen(o_rd_wen), .o_wb_data(o_wb_data), .o_misalign(o_misalign),
    .o_bus_err(o_bus_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Writeback monitor: every o_vld must match the oldest queued expectation.
  always @(negedge i_clk) begin
    if (!i_rst && o_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_vld", {31'b0, o_vld}, 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wb_rd",   {27'b0, o_rd_waddr}, {27'b0, e.rd});
        check("wb_wen",  {31'b0, o_rd_wen},   {31'b0, e.wen});
        check("wb_data", o_wb_data,           e.data);
        check("wb_mis",  {31'b0, o_misalign}, {31'b0, e.mis});
        check("wb_berr", {31'b0, o_bus_err},  {31'b0, e.err});
        $display("[TB] wb rd=%0d wen=%0b data=%08h mis=%0b err=%0b",
                 o_rd_waddr, o_rd_wen, o_wb_data, o_misalign, o_bus_err);
      end
    end
  end

  task automatic alu_txn(input logic [31:0] res, input logic [4:0] rd, input logic wen);
    exp_t e;
    @(negedge i_clk);
    i_vld = 1'b1; i_dmem_ren = 1'b0; i_dmem_wen = 1'b0;
    i_res = res; i_rd_waddr = rd; i_rd_wen = wen;
    #1 check("alu_stall", {31'b0, o_stall}, 32'h0);
    e = '{rd: rd, wen: wen, data: res, mis: 1'b0, err: 1'b0};
    exp_q.push_back(e);
    @(posedge i_clk); #1;
    i_vld = 1'b0; i_rd_wen = 1'b0;
    check("alu_vld", {31'b0, o_vld}, 32'h1);
  endtask

  task automatic mis_txn(input string tag, input logic [2:0] op, input logic ld,
                         input logic [31:0] addr, input logic [4:0] rd, input logic [31:0] res);
    exp_t e;
    @(negedge i_clk);
    i_vld = 1'b1; i_opsel = op; i_dmem_ren = ld; i_dmem_wen = !ld;
    i_addr = addr; i_rd_waddr = rd; i_rd_wen = 1'b1; i_res = res;
    #1;
    check({tag, "_stall"}, {31'b0, o_stall}, 32'h0);
    check({tag, "_req"},   {31'b0, o_req},   32'h0);
    e = '{rd: rd, wen: 1'b0, data: res, mis: 1'b1, err: 1'b0};
    exp_q.push_back(e);
    @(posedge i_clk); #1;
    i_vld = 1'b0; i_dmem_ren = 1'b0; i_dmem_wen = 1'b0; i_rd_wen = 1'b0;
    check({tag, "_req_after"}, {31'b0, o_req}, 32'h0);
    check({tag, "_vld"}, {31'b0, o_vld}, 32'h1);
  endtask

  // gdly < 0: grant never comes; rdly < 0: read data never comes.
  task automatic mem_txn(input string tag, input logic [2:0] op, input logic ld,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                         input int gdly, input int rdly, input logic [31:0] rdata,
                         input logic [3:0] emask, input logic [31:0] ebw, input logic [31:0] edata);
    exp_t e;
    int   n;
    logic err;
    err = (gdly < 0) || (ld && rdly < 0);
    @(negedge i_clk);
    i_vld = 1'b1; i_opsel = op; i_dmem_ren = ld; i_dmem_wen = !ld;
    i_addr = addr; i_wdata = wdata; i_rd_waddr = rd; i_rd_wen = ld; i_res = 32'h0BAD0BAD;
    #1 check({tag, "_stall_idle"}, {31'b0, o_stall}, 32'h1);
    e = '{rd: rd, wen: ld && !err, data: (ld && !err) ? edata : 32'h0, mis: 1'b0, err: err};
    exp_q.push_back(e);
    @(posedge i_clk); #1;
    i_vld = 1'b0; i_dmem_ren = 1'b0; i_dmem_wen = 1'b0; i_addr = '0; i_wdata = '0;
    check({tag, "_req"},   {31'b0, o_req},   32'h1);
    check({tag, "_baddr"}, o_bus_addr,       {addr[31:2], 2'b00});
    check({tag, "_mask"},  {28'b0, o_bus_mask}, {28'b0, emask});
    check({tag, "_bwd"},   o_bus_wdata,      ebw);
    check({tag, "_bwen"},  {31'b0, o_bus_wen}, {31'b0, !ld});
    if (gdly < 0) begin
      n = 0;
      while (o_req === 1'b1 && n < 4 * MAX_WAIT) begin
        n++;
        @(posedge i_clk); #1;
      end
      check({tag, "_req_cycles"}, n, MAX_WAIT);
    end else begin
      for (int k = 0; k < gdly; k++) begin
        i_rvalid = 1'b1; i_rdata = 32'hDEADBEEF;
        @(posedge i_clk); #1;
      end
      i_rvalid = 1'b0; i_rdata = '0;
      check({tag, "_req_held"}, {31'b0, o_req}, 32'h1);
      i_gnt = 1'b1;
      @(posedge i_clk); #1;
      i_gnt = 1'b0;
      if (ld) begin
        check({tag, "_wait_stall"}, {31'b0, o_stall}, 32'h1);
        if (rdly < 0) begin
          n = 0;
          while (o_stall === 1'b1 && n < 4 * MAX_WAIT) begin
            n++;
            @(posedge i_clk); #1;
          end
          check({tag, "_wait_cycles"}, n, MAX_WAIT);
        end else begin
          for (int k = 0; k < rdly; k++) begin
            i_gnt = 1'b1;
            @(posedge i_clk); #1;
            i_gnt = 1'b0;
          end
          i_rdata = rdata; i_rvalid = 1'b1;
          @(posedge i_clk); #1;
          i_rvalid = 1'b0; i_rdata = '0;
        end
      end
    end
    check({tag, "_done_stall"}, {31'b0, o_stall}, 32'h0);
    check({tag, "_done_req"},   {31'b0, o_req},   32'h0);
    i_vld = 1'b1; i_res = 32'h55555555; i_rd_waddr = 5'd3; i_rd_wen = 1'b1;
    @(posedge i_clk); #1;
    i_vld = 1'b0; i_rd_wen = 1'b0;
    check({tag, "_vld"}, {31'b0, o_vld}, 32'h1);
  endtask

  initial begin
    i_rst = 1'b1; i_vld = 0; i_opsel = 0; i_dmem_ren = 0; i_dmem_wen = 0; i_addr = 0;
    i_wdata = 0; i_res = 0; i_rd_waddr = 0; i_rd_wen = 0; i_gnt = 0; i_rvalid = 0; i_rdata = 0;
    #3;
    check("rst_req",   {31'b0, o_req},      32'h0);
    check("rst_vld",   {31'b0, o_vld},      32'h0);
    check("rst_stall", {31'b0, o_stall},    32'h0);
    check("rst_wen",   {31'b0, o_rd_wen},   32'h0);
    check("rst_mis",   {31'b0, o_misalign}, 32'h0);
    check("rst_berr",  {31'b0, o_bus_err},  32'h0);
    check("rst_data",  o_wb_data,           32'h0);
    @(negedge i_clk); i_rst = 1'b0;

    alu_txn(32'h00001234, 5'd5, 1'b1);
    alu_txn(32'hCAFEBABE, 5'd7, 1'b0);
    alu_txn(32'h0000BEEF, 5'd31, 1'b1);

    mem_txn("sb",  3'b000, 1'b0, 32'h103, 32'h000000AB, 5'd1, 0, 0, 32'h0,
            4'b1000, 32'hABABABAB, 32'h0);
    mem_txn("sh",  3'b001, 1'b0, 32'h102, 32'h1234CDEF, 5'd2, 1, 0, 32'h0,
            4'b1100, 32'hCDEFCDEF, 32'h0);
    mem_txn("sw",  3'b010, 1'b0, 32'h200, 32'hDEADBEEF, 5'd3, 3, 0, 32'h0,
            4'b1111, 32'hDEADBEEF, 32'h0);
    mem_txn("lb",  3'b000, 1'b1, 32'h102, 32'h0, 5'd4, 0, 2, 32'h00800000,
            4'b0100, 32'h0, 32'hFFFFFF80);
    mem_txn("lbu", 3'b100, 1'b1, 32'h102, 32'h0, 5'd6, 0, 2, 32'h00800000,
            4'b0100, 32'h0, 32'h00000080);
    mem_txn("lb1", 3'b000, 1'b1, 32'h101, 32'h0, 5'd8, 2, 0, 32'h00007F00,
            4'b0010, 32'h0, 32'h0000007F);
    mem_txn("lh",  3'b001, 1'b1, 32'h106, 32'h0, 5'd9, 1, 0, 32'h80010000,
            4'b1100, 32'h0, 32'hFFFF8001);
    mem_txn("lhu", 3'b101, 1'b1, 32'h106, 32'h0, 5'd10, 1, 1, 32'h80010000,
            4'b1100, 32'h0, 32'h00008001);
    mem_txn("lw",  3'b010, 1'b1, 32'h108, 32'h0, 5'd11, 0, 0, 32'h12345678,
            4'b1111, 32'h0, 32'h12345678);
    mem_txn("lw_gto", 3'b010, 1'b1, 32'h10C, 32'h0, 5'd12, -1, 0, 32'h0,
            4'b1111, 32'h0, 32'h0);
    mem_txn("lhu_rto", 3'b101, 1'b1, 32'h10E, 32'h0, 5'd13, 0, -1, 32'h0,
            4'b1100, 32'h0, 32'h0);

    mis_txn("mis_lw",  3'b010, 1'b1, 32'h102, 5'd14, 32'h00007714);
    mis_txn("mis_lh",  3'b001, 1'b1, 32'h101, 5'd15, 32'h00007715);
    mis_txn("mis_sw",  3'b010, 1'b0, 32'h203, 5'd16, 32'h00007716);
    mis_txn("ill_011", 3'b011, 1'b1, 32'h100, 5'd17, 32'h00007717);
    mis_txn("ill_110", 3'b110, 1'b0, 32'h100, 5'd18, 32'h00007718);

    // Reset while waiting for read data, then a stray rvalid.
    @(negedge i_clk);
    i_vld = 1'b1; i_opsel = 3'b010; i_dmem_ren = 1'b1; i_addr = 32'h300; i_rd_waddr = 5'd20; i_rd_wen = 1'b1;
    @(posedge i_clk); #1;
    i_vld = 1'b0; i_dmem_ren = 1'b0; i_rd_wen = 1'b0;
    i_gnt = 1'b1;
    @(posedge i_clk); #1;
    i_gnt = 1'b0;
    check("rstw_pre_stall", {31'b0, o_stall}, 32'h1);
    #2 i_rst = 1'b1;
    #1;
    check("rstw_req",   {31'b0, o_req},   32'h0);
    check("rstw_vld",   {31'b0, o_vld},   32'h0);
    check("rstw_stall", {31'b0, o_stall}, 32'h0);
    @(negedge i_clk); i_rst = 1'b0;
    @(posedge i_clk); #1;
    i_rvalid = 1'b1; i_rdata = 32'h11223344;
    @(posedge i_clk); #1;
    i_rvalid = 1'b0;
    check("rstw_post_vld",   {31'b0, o_vld},   32'h0);
    check("rstw_post_stall", {31'b0, o_stall}, 32'h0);

    // Reset while requesting: o_req must drop without waiting for a clock edge.
    @(negedge i_clk);
    i_vld = 1'b1; i_opsel = 3'b000; i_dmem_wen = 1'b1; i_addr = 32'h304; i_rd_waddr = 5'd21;
    @(posedge i_clk); #1;
    i_vld = 1'b0; i_dmem_wen = 1'b0;
    check("rstr_pre_req", {31'b0, o_req}, 32'h1);
    #2 i_rst = 1'b1;
    #1 check("rstr_req", {31'b0, o_req}, 32'h0);
    @(negedge i_clk); i_rst = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rstr_post_vld", {31'b0, o_vld}, 32'h0);

    alu_txn(32'h0000ACE1, 5'd22, 1'b1);
    repeat (2) @(posedge i_clk);
    #1 check("sb_empty", exp_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
